// File: rtl/fetch_stage.sv
// Instruction fetch: PC sequencing over a variable-latency request/ack memory port,
// one-entry skid buffer for stalled decode, and the IF/ID pipeline register.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        StallF,
    input  logic        StallD,
    input  logic        PCSrcD,
    input  logic [31:0] PCBranchD,
    input  logic        JumpD,
    input  logic [31:0] PCJumpD,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] PCF,
    output logic [31:0] InstrD,
    output logic [31:0] PCPlus4D,
    output logic        ValidD
);
    localparam int unsigned XLEN = 32;

    typedef enum logic [1:0] {
        WAIT = 2'd0,
        REQ  = 2'd1,
        DROP = 2'd2
    } state_t;

    state_t            state;
    logic [XLEN-1:0]   fetchPc;
    logic [XLEN-1:0]   redirPc;
    logic              bufValid;
    logic [XLEN-1:0]   bufInstr;
    logic [XLEN-1:0]   bufPc4;

    logic              redirect;
    logic              ack;
    logic              accept;
    logic              toBuf;
    logic              bufValidNext;
    logic [XLEN-1:0]   target;
    logic [XLEN-1:0]   fetchPc4;

    // Redirect decode and skid-buffer occupancy after the coming edge.
    always_comb begin
        redirect     = (PCSrcD | JumpD) & ~StallD;
        target       = PCSrcD ? PCBranchD : PCJumpD;
        ack          = imem_ready & (state != WAIT);
        accept       = ack & (state == REQ) & ~redirect;
        toBuf        = accept & (StallD | bufValid);
        fetchPc4     = fetchPc + XLEN'(4);
        bufValidNext = bufValid;
        if (redirect) begin
            bufValidNext = 1'b0;
        end else if (toBuf) begin
            bufValidNext = 1'b1;
        end else if (bufValid && !StallD) begin
            bufValidNext = 1'b0;
        end
    end

    assign imem_req  = (state != WAIT);
    assign imem_addr = fetchPc;
    assign PCF       = fetchPc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= WAIT;
            fetchPc  <= RESET_PC;
            redirPc  <= '0;
            bufValid <= 1'b0;
            bufInstr <= '0;
            bufPc4   <= '0;
            InstrD   <= '0;
            PCPlus4D <= '0;
            ValidD   <= 1'b0;
        end else begin
            bufValid <= bufValidNext;
            if (toBuf) begin
                bufInstr <= imem_rdata;
                bufPc4   <= fetchPc4;
            end

            // IF/ID: redirect bubble beats buffered word beats fresh ack.
            if (!StallD) begin
                if (redirect) begin
                    InstrD   <= '0;
                    PCPlus4D <= '0;
                    ValidD   <= 1'b0;
                end else if (bufValid) begin
                    InstrD   <= bufInstr;
                    PCPlus4D <= bufPc4;
                    ValidD   <= 1'b1;
                end else if (accept) begin
                    InstrD   <= imem_rdata;
                    PCPlus4D <= fetchPc4;
                    ValidD   <= 1'b1;
                end else begin
                    InstrD   <= '0;
                    PCPlus4D <= '0;
                    ValidD   <= 1'b0;
                end
            end

            unique case (state)
                WAIT: begin
                    if (redirect) begin
                        fetchPc <= target;
                    end
                    if (!bufValidNext && !StallF) begin
                        state <= REQ;
                    end
                end
                REQ: begin
                    if (imem_ready) begin
                        fetchPc <= redirect ? target : fetchPc4;
                        if (StallF || bufValidNext) begin
                            state <= WAIT;
                        end
                    end else if (redirect) begin
                        redirPc <= target;
                        state   <= DROP;
                    end
                end
                DROP: begin
                    // A redirect arriving with the ack is the newest target.
                    if (redirect) begin
                        redirPc <= target;
                    end
                    if (imem_ready) begin
                        fetchPc <= redirect ? target : redirPc;
                        state   <= StallF ? WAIT : REQ;
                    end
                end
                default: state <= WAIT;
            endcase
        end
    end
endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: per-cycle vector table on zero-wait memory, a scoreboarded
// wait-state/jump sequence, and reset asserted while a request is being dropped.
module tb_fetch_stage;
    logic        clk;
    logic        rst_n;
    logic        StallF, StallD, PCSrcD, JumpD;
    logic [31:0] PCBranchD, PCJumpD;
    logic        imem_req, imem_ready;
    logic [31:0] imem_addr, imem_rdata;
    logic [31:0] PCF, InstrD, PCPlus4D;
    logic        ValidD;

    int total;
    int bad;

    logic autoMem;
    logic readyMan;
    int   waitCfg;
    int   waitCnt;

    typedef struct packed {
        logic        stallF;
        logic        stallD;
        logic        pcSrc;
        logic [31:0] brT;
        logic        jump;
        logic [31:0] jT;
        logic        expReq;
        logic [31:0] expAddr;
        logic        expValid;
        logic [31:0] expPc;
    } vec_t;

    fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .rst_n(rst_n),
        .StallF(StallF), .StallD(StallD),
        .PCSrcD(PCSrcD), .PCBranchD(PCBranchD),
        .JumpD(JumpD), .PCJumpD(PCJumpD),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ready(imem_ready), .imem_rdata(imem_rdata),
        .PCF(PCF), .InstrD(InstrD), .PCPlus4D(PCPlus4D), .ValidD(ValidD)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] memWord(input logic [31:0] a);
        return {~a[15:0], a[15:0]};
    endfunction

    // Memory model: acks after waitCfg extra cycles, or under direct bench control.
    assign imem_ready = autoMem ? (imem_req && (waitCnt == waitCfg)) : readyMan;
    assign imem_rdata = memWord(imem_addr);

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) waitCnt <= 0;
        else if (!imem_req || imem_ready) waitCnt <= 0;
        else waitCnt <= waitCnt + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic setIn(input logic sF, input logic sD, input logic ps, input logic [31:0] bt,
                         input logic jp, input logic [31:0] jt);
        StallF = sF; StallD = sD; PCSrcD = ps; PCBranchD = bt; JumpD = jp; PCJumpD = jt;
    endtask

    function automatic vec_t mk(input logic sF, input logic sD, input logic ps, input logic [31:0] bt,
                                input logic jp, input logic [31:0] jt, input logic er,
                                input logic [31:0] ea, input logic ev, input logic [31:0] ep);
        vec_t v;
        v.stallF = sF; v.stallD = sD; v.pcSrc = ps; v.brT = bt; v.jump = jp; v.jT = jt;
        v.expReq = er; v.expAddr = ea; v.expValid = ev; v.expPc = ep;
        return v;
    endfunction

    // Assert reset, check reset outputs, release right after a rising edge (cycle 0).
    task automatic doReset();
        setIn(0, 0, 0, 0, 0, 0);
        rst_n = 1'b0;
        #1;
        check("rst_req", 32'(imem_req), 0);
        check("rst_pcf", PCF, 32'h0);
        check("rst_valid", 32'(ValidD), 0);
        check("rst_instr", InstrD, 32'h0);
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        vec_t        vecs[16];
        logic [31:0] expQ[$];
        logic [31:0] e;
        logic [31:0] prevAddr;
        logic        prevPend;

        total = 0; bad = 0;
        autoMem = 1'b1; readyMan = 1'b0; waitCfg = 0;
        rst_n = 1'b1;
        setIn(0, 0, 0, 0, 0, 0);

        //              sF sD ps brT       jp jT        req addr     v  pc
        vecs[0]  = mk(0, 0, 0, 0,        0, 0,        0, 32'h000,  0, 0);
        vecs[1]  = mk(0, 0, 0, 0,        0, 0,        1, 32'h000,  0, 0);
        vecs[2]  = mk(0, 0, 0, 0,        0, 0,        1, 32'h004,  1, 32'h000);
        vecs[3]  = mk(1, 1, 0, 0,        0, 0,        1, 32'h008,  1, 32'h004);
        vecs[4]  = mk(1, 1, 0, 0,        0, 0,        0, 32'h00C,  1, 32'h004);
        vecs[5]  = mk(0, 0, 0, 0,        0, 0,        0, 32'h00C,  1, 32'h004);
        vecs[6]  = mk(0, 0, 0, 0,        0, 0,        1, 32'h00C,  1, 32'h008);
        vecs[7]  = mk(0, 0, 1, 32'h040,  0, 0,        1, 32'h010,  1, 32'h00C);
        vecs[8]  = mk(0, 0, 0, 0,        0, 0,        1, 32'h040,  0, 0);
        vecs[9]  = mk(0, 0, 1, 32'h080,  1, 32'h200,  1, 32'h044,  1, 32'h040);
        vecs[10] = mk(0, 0, 0, 0,        0, 0,        1, 32'h080,  0, 0);
        vecs[11] = mk(1, 0, 0, 0,        0, 0,        1, 32'h084,  1, 32'h080);
        vecs[12] = mk(1, 0, 0, 0,        1, 32'h300,  0, 32'h088,  1, 32'h084);
        vecs[13] = mk(0, 0, 0, 0,        0, 0,        0, 32'h300,  0, 0);
        vecs[14] = mk(0, 0, 0, 0,        0, 0,        1, 32'h300,  0, 0);
        vecs[15] = mk(0, 0, 0, 0,        0, 0,        1, 32'h304,  1, 32'h300);

        #2;
        doReset();
        for (int i = 0; i < 16; i++) begin
            check($sformatf("v%0d_req", i), 32'(imem_req), 32'(vecs[i].expReq));
            check($sformatf("v%0d_addr", i), imem_addr, vecs[i].expAddr);
            check($sformatf("v%0d_pcf", i), PCF, vecs[i].expAddr);
            check($sformatf("v%0d_valid", i), 32'(ValidD), 32'(vecs[i].expValid));
            check($sformatf("v%0d_instr", i), InstrD,
                  vecs[i].expValid ? memWord(vecs[i].expPc) : 32'h0);
            check($sformatf("v%0d_pc4", i), PCPlus4D,
                  vecs[i].expValid ? vecs[i].expPc + 32'd4 : 32'h0);
            setIn(vecs[i].stallF, vecs[i].stallD, vecs[i].pcSrc, vecs[i].brT,
                  vecs[i].jump, vecs[i].jT);
            tick();
        end
        setIn(0, 0, 0, 0, 0, 0);

        // Three wait states; jump one cycle into the request for 0x8.
        waitCfg = 3;
        doReset();
        expQ.push_back(32'h0);
        expQ.push_back(32'h4);
        prevPend = 1'b0;
        prevAddr = '0;
        for (int c = 0; c < 24; c++) begin
            if (prevPend) check($sformatf("c%0d_addr_hold", c), imem_addr, prevAddr);
            if (ValidD) begin
                if (expQ.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL scb_extra: got %h expected no instruction (t=%0t)", InstrD, $time);
                end else begin
                    e = expQ.pop_front();
                    check($sformatf("c%0d_scb_instr", c), InstrD, memWord(e));
                    check($sformatf("c%0d_scb_pc4", c), PCPlus4D, e + 32'd4);
                end
            end
            if (c >= 10 && c <= 12) begin
                check($sformatf("c%0d_drop_req", c), 32'(imem_req), 1);
                check($sformatf("c%0d_drop_addr", c), imem_addr, 32'h8);
            end
            if (c == 13) begin
                check("jump_target_req", 32'(imem_req), 1);
                check("jump_target_addr", imem_addr, 32'h100);
            end
            prevPend = imem_req && !imem_ready;
            prevAddr = imem_addr;
            if (c == 10) begin
                setIn(0, 0, 0, 0, 1, 32'h100);
                expQ.push_back(32'h100);
                expQ.push_back(32'h104);
            end else begin
                setIn(0, 0, 0, 0, 0, 0);
            end
            tick();
        end
        check("scb_drained", 32'(expQ.size()), 0);

        // Reset asserted while a dropped request is still outstanding.
        waitCfg = 0;
        doReset();
        tick();
        tick();
        check("pre_drop_valid", 32'(ValidD), 1);
        autoMem = 1'b0;
        readyMan = 1'b0;
        setIn(0, 0, 0, 0, 1, 32'h100);
        tick();
        setIn(0, 0, 0, 0, 0, 0);
        check("drop_req", 32'(imem_req), 1);
        check("drop_addr", imem_addr, 32'h4);
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_req", 32'(imem_req), 0);
        check("midrst_valid", 32'(ValidD), 0);
        check("midrst_pcf", PCF, 32'h0);
        tick();
        autoMem = 1'b1;
        rst_n = 1'b1;
        check("restart_c0_req", 32'(imem_req), 0);
        tick();
        check("restart_c1_req", 32'(imem_req), 1);
        check("restart_c1_addr", imem_addr, 32'h0);
        tick();
        check("restart_c2_valid", 32'(ValidD), 1);
        check("restart_c2_instr", InstrD, memWord(32'h0));
        check("restart_c2_addr", imem_addr, 32'h4);
        tick();
        check("restart_c3_instr", InstrD, memWord(32'h4));
        check("restart_c3_pc4", PCPlus4D, 32'h8);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
